sdram_image_writer: RTL



---
 rtl/gw_loader_pkg.sv | 19 +
 rtl/loader_fifo.sv | 46 ++++
 rtl/sdram_image_writer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/gw_loader_pkg.sv
// Shared types and default region constants for the loader-to-SDRAM image writer.
package gw_loader_pkg;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_REQ,
    WR_GAP
  } wr_state_t;

  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] data;
  } wq_entry_t;

  localparam logic [24:0] DEF_MASK_BASE  = 25'h0000000;
  localparam int          DEF_MASK_WORDS = 1024;
  localparam logic [24:0] DEF_SDRAM_BASE = 25'h0000000;

endpackage

// File: rtl/loader_fifo.sv
// Synchronous FIFO of any entry type; head is visible combinationally, push and pop may coincide.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module loader_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_image_writer.sv
// Packs loader bytes into big-endian 16-bit words; mask-region words go to the LCD mask port, the rest
// are queued and written to SDRAM by req/ack. Word visible 1 cycle after its completing byte; full queue drops.
module sdram_image_writer
  import gw_loader_pkg::*;
#(
  parameter logic [24:0] MASK_BASE  = DEF_MASK_BASE,
  parameter int          MASK_WORDS = DEF_MASK_WORDS,
  parameter logic [24:0] SDRAM_BASE = DEF_SDRAM_BASE,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_sys_99_287,
  input  logic        reset_n,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        dl_done,
  output logic        mask_data_wr,
  output logic [15:0] mask_data,
  output logic        sd_wr,
  output logic [24:0] sd_wr_addr,
  output logic [15:0] sd_data,
  input  logic        sd_wr_ack,
  output logic        busy,
  output logic        overflow
);
  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [25:0] MASK_END = {1'b0, MASK_BASE} + 26'(2 * MASK_WORDS);

  logic        pend_vld, pend_vld_n;
  logic [7:0]  pend_byte, pend_byte_n;
  logic [23:0] pend_tag, pend_tag_n;
  logic        def_vld, def_vld_n;
  logic [7:0]  def_byte, def_byte_n;
  logic [23:0] def_tag, def_tag_n;
  logic        done_d;

  logic        emit_vld;
  logic [23:0] emit_tag;
  logic [15:0] emit_data;
  logic [24:0] byte_addr;
  logic        in_mask;
  logic        push;
  logic        pop;
  logic        flush;
  logic [23:0] wr_tag;

  wq_entry_t   push_entry;
  wq_entry_t   head;
  logic        full;
  logic        empty;
  logic [CW-1:0] count;
  logic [CW-1:0] occ_n;

  wr_state_t   state;

  assign wr_tag = dl_addr[24:1];
  assign flush  = (dl_done && !dl_wr) || done_d;

  // A mismatching odd byte emits two words; the second waits one cycle in def_*.
  always_comb begin
    emit_vld    = 1'b0;
    emit_tag    = pend_tag;
    emit_data   = {pend_byte, 8'h00};
    pend_vld_n  = pend_vld;
    pend_byte_n = pend_byte;
    pend_tag_n  = pend_tag;
    def_vld_n   = 1'b0;
    def_byte_n  = def_byte;
    def_tag_n   = def_tag;
    if (def_vld) begin
      emit_vld  = 1'b1;
      emit_tag  = def_tag;
      emit_data = {8'h00, def_byte};
    end else if (dl_wr) begin
      if (!dl_addr[0]) begin
        emit_vld    = pend_vld;
        pend_vld_n  = 1'b1;
        pend_byte_n = dl_data;
        pend_tag_n  = wr_tag;
      end else if (pend_vld && pend_tag == wr_tag) begin
        emit_vld   = 1'b1;
        emit_data  = {pend_byte, dl_data};
        pend_vld_n = 1'b0;
      end else if (pend_vld) begin
        emit_vld   = 1'b1;
        pend_vld_n = 1'b0;
        def_vld_n  = 1'b1;
        def_byte_n = dl_data;
        def_tag_n  = wr_tag;
      end else begin
        emit_vld  = 1'b1;
        emit_tag  = wr_tag;
        emit_data = {8'h00, dl_data};
      end
    end else if (flush && pend_vld) begin
      emit_vld   = 1'b1;
      pend_vld_n = 1'b0;
    end
  end

  assign byte_addr       = {emit_tag, 1'b0};
  assign in_mask         = ({1'b0, byte_addr} >= {1'b0, MASK_BASE}) && ({1'b0, byte_addr} < MASK_END);
  assign push            = emit_vld && !in_mask;
  assign push_entry.addr = SDRAM_BASE + {1'b0, emit_tag};
  assign push_entry.data = emit_data;
  assign pop             = (state == WR_REQ) && sd_wr_ack;
  assign occ_n           = count + CW'(push && (!full || pop)) - CW'(pop);

  loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (wq_entry_t)
  ) u_fifo (
    .clk       (clk_sys_99_287),
    .rst_n     (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk_sys_99_287 or negedge reset_n) begin
    if (!reset_n) begin
      pend_vld  <= 1'b0;
      pend_byte <= '0;
      pend_tag  <= '0;
      def_vld   <= 1'b0;
      def_byte  <= '0;
      def_tag   <= '0;
      done_d    <= 1'b0;
    end else begin
      pend_vld  <= pend_vld_n;
      pend_byte <= pend_byte_n;
      pend_tag  <= pend_tag_n;
      def_vld   <= def_vld_n;
      def_byte  <= def_byte_n;
      def_tag   <= def_tag_n;
      done_d    <= dl_wr && dl_done;
    end
  end

  // GAP also makes IDLE's decision so a queued write can rise two cycles after the ack.
  always_ff @(posedge clk_sys_99_287 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= WR_IDLE;
      sd_wr        <= 1'b0;
      sd_wr_addr   <= '0;
      sd_data      <= '0;
      mask_data_wr <= 1'b0;
      mask_data    <= '0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      mask_data_wr <= emit_vld && in_mask;
      if (emit_vld && in_mask) mask_data <= emit_data;
      if (push && full && !pop) overflow <= 1'b1;
      busy <= pend_vld_n || def_vld_n || (occ_n != '0);
      case (state)
        WR_IDLE, WR_GAP: begin
          if (!empty) begin
            sd_wr      <= 1'b1;
            sd_wr_addr <= head.addr;
            sd_data    <= head.data;
            state      <= WR_REQ;
          end else begin
            state <= WR_IDLE;
          end
        end
        WR_REQ: begin
          if (sd_wr_ack) begin
            sd_wr <= 1'b0;
            state <= WR_GAP;
          end
        end
        default: begin
          sd_wr <= 1'b0;
          state <= WR_IDLE;
        end
      endcase
    end
  end

endmodule
